// File: rtl/aes_request_arbiter.sv
// Two-requester front end for a shared, iterative AES round datapath.
// Grants one requester at a time (round-robin on contention), captures its
// plaintext and key, sequences the initial key addition, the middle rounds
// and the final round through the external datapath, then holds the
// ciphertext until the owning requester accepts it.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; grant and capture happen here
// LOAD   | initial AddRoundKey with round key 0
// ROUND  | full round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// FINAL  | last round, MixColumns skipped
// RESP   | ciphertext presented to the owner until it is accepted
module aes_request_arbiter #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_data_0,
    input  logic [127:0] req_data_1,
    input  logic [127:0] req_key_0,
    input  logic [127:0] req_key_1,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_start,
    output logic [3:0]   dp_round,
    output logic         dp_sub_en,
    output logic         dp_shift_en,
    output logic         dp_mix_en,
    input  logic [127:0] dp_result,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [127:0] rsp_data,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_RESP  = 3'd4
    } fsm_e;

    localparam logic [3:0] LAST_MID_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_ROUND    = 4'(NUM_ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         owner_q, owner_d;
    logic         last_grant_q, last_grant_d;

    logic         grant_any;
    logic         grant_idx;

    assign grant_any = |req_valid;

    // Pick the requester to serve: a lone requester wins, contention alternates.
    always_comb begin
        grant_idx = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant_q;
            default: grant_idx = 1'b0;
        endcase
    end

    // State, datapath registers and arbitration history.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q        <= S_IDLE;
            state_q      <= '0;
            key_q        <= '0;
            round_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            key_q        <= key_d;
            round_q      <= round_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic: capture on grant, fold datapath result back each round.
    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        key_d        = key_q;
        round_d      = round_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (fsm_q)
            S_IDLE: begin
                if (grant_any) begin
                    owner_d = grant_idx;
                    state_d = grant_idx ? req_data_1 : req_data_0;
                    key_d   = grant_idx ? req_key_1  : req_key_0;
                    round_d = 4'd0;
                    fsm_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = dp_result;
                round_d = 4'd1;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = dp_result;
                round_d = round_q + 4'd1;
                if (round_q == LAST_MID_ROUND) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = dp_result;
                round_d = 4'd0;
                fsm_d   = S_RESP;
            end
            S_RESP: begin
                // Only the owner's accept counts; the other ready bit is ignored.
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    fsm_d        = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // Output decode; req_ready is masked during reset so every output is quiet.
    always_comb begin
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        dp_start    = 1'b0;
        dp_round    = 4'd0;
        dp_sub_en   = 1'b0;
        dp_shift_en = 1'b0;
        dp_mix_en   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (n_rst && grant_any) begin
                    req_ready = grant_idx ? 2'b10 : 2'b01;
                end
            end
            S_LOAD: begin
                dp_start = 1'b1;
            end
            S_ROUND: begin
                dp_round    = round_q;
                dp_sub_en   = 1'b1;
                dp_shift_en = 1'b1;
                dp_mix_en   = 1'b1;
            end
            S_FINAL: begin
                dp_round    = FINAL_ROUND;
                dp_sub_en   = 1'b1;
                dp_shift_en = 1'b1;
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    assign dp_state = state_q;
    assign dp_key   = key_q;
    assign rsp_data = state_q;
    assign busy     = (fsm_q != S_IDLE);
    assign owner    = owner_q;

endmodule

// File: tb/tb_aes_request_arbiter.sv
// Bench for aes_request_arbiter: supplies an AES-128 round datapath, drives
// random and known-answer requests, and compares the control schedule and
// ciphertext against an arithmetic AES model and a round-robin grant model.
module tb_aes_request_arbiter;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data_0, req_data_1, req_key_0, req_key_1;
    logic [127:0] dp_state, dp_key, dp_result, rsp_data;
    logic         dp_start, dp_sub_en, dp_shift_en, dp_mix_en;
    logic [3:0]   dp_round;
    logic [1:0]   rsp_valid, rsp_ready;
    logic         busy, owner;

    int total = 0;
    int bad   = 0;

    aes_request_arbiter #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_0(req_data_0), .req_data_1(req_data_1),
        .req_key_0(req_key_0), .req_key_1(req_key_1),
        .dp_state(dp_state), .dp_key(dp_key), .dp_start(dp_start),
        .dp_round(dp_round), .dp_sub_en(dp_sub_en), .dp_shift_en(dp_shift_en),
        .dp_mix_en(dp_mix_en), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the definition: multiplicative inverse (a^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, e, b;
        e   = 8'd254;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, a);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        {w0, w1, w2, w3} = key;
        for (int i = 1; i <= r; i++) begin
            t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
            t[31:24] = t[31:24] ^ rc;
            rc = xt(rc);
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] data);
        logic [127:0] s;
        s = data ^ key;
        for (int r = 1; r < NR; r++)
            s = mix_columns(shift_rows(sub_bytes(s))) ^ round_key(key, r);
        return shift_rows(sub_bytes(s)) ^ round_key(key, NR);
    endfunction

    // Shared datapath the DUT drives: optional transforms, then AddRoundKey.
    always_comb begin
        logic [127:0] s;
        s = dp_state;
        if (dp_sub_en)   s = sub_bytes(s);
        if (dp_shift_en) s = shift_rows(s);
        if (dp_mix_en)   s = mix_columns(s);
        dp_result = s ^ round_key(dp_key, int'(dp_round));
    end

    // ---------------- checking helpers ----------------
    logic [12:0] ctrl_obs;
    assign ctrl_obs = {busy, req_ready, rsp_valid, dp_start, dp_round, dp_sub_en, dp_shift_en, dp_mix_en};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Control schedule k cycles after the accepting edge, from the round rules.
    function automatic logic [12:0] exp_phase(input int k);
        if (k == 1)       return {1'b1, 2'b00, 2'b00, 1'b1, 4'd0, 3'b000};
        else if (k <= NR) return {1'b1, 2'b00, 2'b00, 1'b0, 4'(k - 1), 3'b111};
        else              return {1'b1, 2'b00, 2'b00, 1'b0, 4'(NR), 3'b110};
    endfunction

    // Serve one job: caller has set req_valid/data in IDLE at posedge+1.
    task automatic serve(input logic who, input logic [127:0] exp_ct, input int hold, input bit scramble);
        logic [1:0]   oh;
        logic [127:0] k_acc, d_acc;
        oh    = who ? 2'b10 : 2'b01;
        k_acc = who ? req_key_1 : req_key_0;
        d_acc = who ? req_data_1 : req_data_0;
        #1;
        check_ctrl("grant", ctrl_obs, {1'b0, oh, 2'b00, 1'b0, 4'd0, 3'b000});
        tick();
        check_bit("owner", owner, who);
        if (scramble) begin
            if (who) begin req_key_1 = rand128(); req_data_1 = rand128(); end
            else     begin req_key_0 = rand128(); req_data_0 = rand128(); end
        end
        check_blk("captured_key", dp_key, k_acc);
        check_blk("captured_data", dp_state, d_acc);
        for (int k = 1; k <= NR + 1; k++) begin
            check_ctrl("phase", ctrl_obs, exp_phase(k));
            tick();
        end
        rsp_ready = ~oh;
        for (int h = 0; h <= hold; h++) begin
            check_ctrl("resp_ctrl", ctrl_obs, {1'b1, 2'b00, oh, 1'b0, 4'd0, 3'b000});
            check_blk("rsp_data", rsp_data, exp_ct);
            if (h < hold) tick();
        end
        rsp_ready = ($urandom_range(0, 1) == 1) ? 2'b11 : oh;
        tick();
        rsp_ready = 2'b00;
        check_bit("idle_after_rsp", busy, 1'b0);
        check_ctrl("no_rsp_after", {11'd0, rsp_valid}, 13'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic         lg;
        logic         who;
        logic [1:0]   pat;
        logic [127:0] fips_key, fips_pt, fips_ct;

        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_pt  = 128'h00112233445566778899aabbccddeeff;
        fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        n_rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_data_0 = '0; req_data_1 = '0; req_key_0 = '0; req_key_1 = '0;
        tick();
        tick();
        check_ctrl("reset_ctrl", ctrl_obs, 13'd0);
        check_blk("reset_state", dp_state, '0);
        check_blk("reset_key", dp_key, '0);
        check_blk("reset_rsp_data", rsp_data, '0);
        check_bit("reset_owner", owner, 1'b0);
        n_rst = 1'b1;
        tick();
        lg = 1'b1;

        // both requesters held valid: grants alternate starting with 0
        req_data_0 = rand128(); req_key_0 = rand128();
        req_data_1 = rand128(); req_key_1 = rand128();
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            who = ~lg;
            serve(who, aes_ref(who ? req_key_1 : req_key_0, who ? req_data_1 : req_data_0),
                  int'($urandom_range(0, 3)), 1'b1);
            lg = who;
        end
        req_valid = 2'b00;
        tick();

        // known-answer vector, inputs scrambled right after acceptance
        req_key_0 = fips_key;
        req_data_0 = fips_pt;
        req_valid = 2'b01;
        serve(1'b0, fips_ct, 0, 1'b1);
        lg = 1'b0;

        // long response stall with both requesters still asking
        req_data_0 = rand128(); req_key_0 = rand128();
        req_data_1 = rand128(); req_key_1 = rand128();
        req_valid = 2'b11;
        serve(1'b1, aes_ref(req_key_1, req_data_1), 20, 1'b0);
        serve(1'b0, aes_ref(req_key_0, req_data_0), 2, 1'b0);
        lg = 1'b0;
        req_valid = 2'b00;
        tick();

        // reset in the middle of round 5
        req_data_0 = rand128(); req_key_0 = rand128();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            check_ctrl("pre_reset_phase", ctrl_obs, exp_phase(k));
            if (k < 6) tick();
        end
        n_rst = 1'b0;
        #1;
        check_ctrl("midreset_ctrl", ctrl_obs, 13'd0);
        check_blk("midreset_state", dp_state, '0);
        check_blk("midreset_key", dp_key, '0);
        check_blk("midreset_rsp_data", rsp_data, '0);
        check_bit("midreset_owner", owner, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        n_rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check_ctrl("dropped_job_quiet", ctrl_obs, 13'd0);
        end
        lg = 1'b1;

        // last grant restored to 1 by reset, so contention goes to requester 0
        req_data_0 = rand128(); req_key_0 = rand128();
        req_data_1 = rand128(); req_key_1 = rand128();
        req_valid = 2'b11;
        serve(1'b0, aes_ref(req_key_0, req_data_0), 1, 1'b0);
        lg = 1'b0;

        // random request patterns against the round-robin model
        for (int j = 0; j < 8; j++) begin
            req_data_0 = rand128(); req_key_0 = rand128();
            req_data_1 = rand128(); req_key_1 = rand128();
            pat = 2'($urandom_range(1, 3));
            req_valid = pat;
            who = (pat == 2'b11) ? ~lg : pat[1];
            serve(who, aes_ref(who ? req_key_1 : req_key_0, who ? req_data_1 : req_data_0),
                  int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1));
            lg = who;
        end
        req_valid = 2'b00;
        tick();
        check_ctrl("final_idle", ctrl_obs, 13'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
